// File: rtl/sysid_chk_pkg.sv
// Shared types and helpers for the sysid boot-time checker.
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_COMPARE, S_BACKOFF, S_DONE
  } state_t;

  localparam logic SYSID_OFS_ID = 1'b0;
  localparam logic SYSID_OFS_TS = 1'b1;

  // Width able to hold 0..max_val-1 (the counter is loaded with N-1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/sysid_boot_checker.sv
// Reads sysid ID/timestamp over Avalon-MM at boot, compares against build
// constants, retries with backoff, and reports pass/fail to the sequencer.
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1766422800,
  parameter int          READ_LATENCY       = 0,
  parameter int          MAX_RETRIES        = 3,
  parameter int          RETRY_DELAY        = 16,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        mismatch_id,
  output logic        mismatch_ts,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int CNT_MAX_A = (TIMEOUT_CYCLES > RETRY_DELAY) ? TIMEOUT_CYCLES : RETRY_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > READ_LATENCY) ? CNT_MAX_A : READ_LATENCY;
  localparam int CW        = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] LD_TO  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LD_LAT = CW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [CW-1:0] LD_BO  = CW'(RETRY_DELAY - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [3:0]      attempts;
  logic            auto_pend;
  logic            start_ok, rd_state, accept, stall_expire, match, retry;
  state_t          fail_state;

  assign start_ok     = ((state == S_IDLE) && (start || auto_pend)) || ((state == S_DONE) && start);
  assign rd_state     = (state == S_RD_ID) || (state == S_RD_TS);
  assign accept       = rd_state && !m_waitrequest;
  assign stall_expire = rd_state && m_waitrequest && (cnt == '0);
  assign match        = (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TIMESTAMP);
  assign retry        = attempts < 4'(MAX_RETRIES);
  assign fail_state   = retry ? S_BACKOFF : S_DONE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_RD_ID;
      S_RD_ID:   if (accept) state_nxt = (READ_LATENCY == 0) ? S_RD_TS : S_WAIT_ID;
                 else if (stall_expire) state_nxt = fail_state;
      S_WAIT_ID: if (cnt == '0) state_nxt = S_RD_TS;
      S_RD_TS:   if (accept) state_nxt = (READ_LATENCY == 0) ? S_COMPARE : S_WAIT_TS;
                 else if (stall_expire) state_nxt = fail_state;
      S_WAIT_TS: if (cnt == '0) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = match ? S_DONE : fail_state;
      S_BACKOFF: if (cnt == '0) state_nxt = S_RD_ID;
      S_DONE:    if (start_ok) state_nxt = S_RD_ID;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = !((state == S_IDLE) || (state == S_DONE));
    done = (state == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_read      <= 1'b0;
      m_address   <= SYSID_OFS_ID;
      cnt         <= '0;
      attempts    <= '0;
      auto_pend   <= AUTO_START;
      pass        <= 1'b0;
      mismatch_id <= 1'b0;
      mismatch_ts <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      // Registered read strobe follows the state being entered.
      m_read    <= (state_nxt == S_RD_ID) || (state_nxt == S_RD_TS);
      m_address <= (state_nxt == S_RD_TS) ? SYSID_OFS_TS : SYSID_OFS_ID;
      if (state != S_IDLE) auto_pend <= 1'b0;

      // One counter: timeout in RD_*, latency in WAIT_*, delay in BACKOFF.
      if (state_nxt != state) begin
        case (state_nxt)
          S_RD_ID, S_RD_TS:     cnt <= LD_TO;
          S_WAIT_ID, S_WAIT_TS: cnt <= LD_LAT;
          S_BACKOFF:            cnt <= LD_BO;
          default:              cnt <= '0;
        endcase
      end else if ((cnt != '0) && ((state == S_WAIT_ID) || (state == S_WAIT_TS) ||
                                   (state == S_BACKOFF) || (rd_state && m_waitrequest))) begin
        cnt <= cnt - 1'b1;
      end

      if ((state_nxt == S_RD_TS) && (state inside {S_RD_ID, S_WAIT_ID}))
        captured_id <= m_readdata;
      if ((state_nxt == S_COMPARE) && (state inside {S_RD_TS, S_WAIT_TS}))
        captured_ts <= m_readdata;

      if (stall_expire) timeout <= 1'b1;

      if (state == S_COMPARE) begin
        mismatch_id <= (captured_id != EXPECTED_ID);
        mismatch_ts <= (captured_ts != EXPECTED_TIMESTAMP);
        if (match) pass <= 1'b1;
      end

      if ((state_nxt == S_BACKOFF) && (state != S_BACKOFF)) attempts <= attempts + 1'b1;

      if ((state == S_BACKOFF) && (state_nxt == S_RD_ID)) begin
        mismatch_id <= 1'b0;
        mismatch_ts <= 1'b0;
        timeout     <= 1'b0;
      end

      if (start_ok) begin
        pass        <= 1'b0;
        mismatch_id <= 1'b0;
        mismatch_ts <= 1'b0;
        timeout     <= 1'b0;
        attempts    <= '0;
      end
    end
  end

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Boot-time consumer of the system-ID peripheral. After reset (or on `start`), it reads the 32-bit ID word at offset 0 and the build timestamp at offset 1 over an Avalon-MM read-master port. It compares both words against the values baked into the build and reports pass/fail, retrying on failure. It sits between the sysid slave and the boot/reset sequencer, which holds the processor until `done` and `pass` are high.

## Interface
Parameters:
- `EXPECTED_ID`, 32'd0: expected word at offset 0.
- `EXPECTED_TIMESTAMP`, 32'd1766422800: expected word at offset 1.
- `READ_LATENCY`, 0: cycles from read accept to valid `m_readdata`. Legal range 0..3.
- `MAX_RETRIES`, 3: extra attempts after the first failure. Legal range 0..15.
- `RETRY_DELAY`, 16: idle cycles between attempts. Must be ≥1.
- `TIMEOUT_CYCLES`, 255: maximum cycles a read may stall on waitrequest. Must be ≥1.
- `AUTO_START`, 1: start one attempt automatically after reset release.

Ports:
- `clock`  in  1  single clock domain.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a check. Ignored while `busy`.
- `m_address`  out  1  sysid word select: 0 = ID, 1 = timestamp.
- `m_read`  out  1  read request.
- `m_waitrequest`  in  1  slave stall.
- `m_readdata`  in  32  read data.
- `busy`  out  1  check in progress.
- `done`  out  1  level. High once a check completes; held until the next accepted start.
- `pass`  out  1  valid when `done` is high. Both words matched on some attempt.
- `mismatch_id`  out  1  the last attempt's ID word differed.
- `mismatch_ts`  out  1  the last attempt's timestamp word differed.
- `timeout`  out  1  the last attempt aborted on a waitrequest timeout.
- `captured_id`  out  32  ID word from the last attempt.
- `captured_ts`  out  32  timestamp word from the last attempt.

## Operation
- The FSM states are IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE, BACKOFF, DONE.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including `captured_*`.
  - The attempt counter is 0.
- IDLE moves to RD_ID on `start`. If `AUTO_START=1`, it also moves to RD_ID on the first clock after reset release.
- RD_ID and RD_TS:
  - `m_read` is high, with `m_address` set to 0 or 1 respectively.
  - Address and read are held stable while `m_waitrequest` is high.
  - A read is accepted on the cycle where `m_waitrequest` is low.
- Data capture:
  - With `READ_LATENCY=0`, data is captured on the accept cycle and the WAIT_* state is skipped.
  - Otherwise the FSM enters WAIT_* and captures data exactly `READ_LATENCY` cycles after accept, with `m_read` low.
- Timeout: if waitrequest stays high for `TIMEOUT_CYCLES` consecutive cycles in RD_*, the FSM drops `m_read`, sets `timeout`, and treats the attempt as failed. It goes straight to the retry decision and skips COMPARE.
- COMPARE (one cycle):
  - `mismatch_id` is updated to `captured_id != EXPECTED_ID`.
  - `mismatch_ts` is updated to `captured_ts != EXPECTED_TIMESTAMP`.
  - If both match: `pass`=1, go to DONE.
- Retry decision on failure:
  - If the attempt count is below `MAX_RETRIES`, increment it and enter BACKOFF for `RETRY_DELAY` cycles, then go to RD_ID. `mismatch_*` and `timeout` are cleared on BACKOFF exit.
  - Otherwise go to DONE with `pass`=0.
- DONE: `done`=1, `busy`=0. A `start` clears `done`, `pass`, the mismatch flags, `timeout` and the attempt count, then enters RD_ID.
- `busy` is high in every state except IDLE and DONE.
- Simultaneous events:
  - A `start` during `busy` is dropped.
  - `reset_n` asserted mid-read drops `m_read` immediately (asynchronous) and discards all state.

## Timing
- Zero-wait slave, `READ_LATENCY=0`, start sampled at edge 0:
  - RD_ID during cycle 1.
  - RD_TS during cycle 2.
  - COMPARE during cycle 3.
  - `done`/`pass` high from cycle 4.
- Each waitrequest cycle adds 1 cycle. Each unit of `READ_LATENCY` adds 1 cycle per word.
- Failed attempt to next RD_ID: 1 (COMPARE) + `RETRY_DELAY` cycles.
- `m_read` is registered. It is never high in COMPARE, BACKOFF, DONE or IDLE.

## Structure
- Package `sysid_chk_pkg`:
  - FSM state enum.
  - Offset constants `SYSID_OFS_ID=1'b0` and `SYSID_OFS_TS=1'b1`.
  - Counter-width function (clog2 helper).
- A single module with no sub-modules. A shared down-counter serves latency, timeout and backoff, since these are never active together.

## Test plan
- Zero-wait sysid model returning 0 / 1766422800, AUTO_START=1 → `done` and `pass` high 5 cycles after reset release, `mismatch_*`=0, `timeout`=0.
- Model returns timestamp 1766422801 → 4 attempts separated by 16-cycle gaps, then `done`=1, `pass`=0, `mismatch_ts`=1, `mismatch_id`=0, `captured_ts`=1766422801.
- Waitrequest held 3 cycles per read, READ_LATENCY=2 → address/read stable during stall, correct capture, `pass`=1, total latency matches the formula.
- Waitrequest stuck high with TIMEOUT_CYCLES=8 and MAX_RETRIES=0 → `m_read` drops after 8 cycles, `timeout`=1, `done`=1, `pass`=0.
- First attempt ID=5, then model corrected → second attempt passes, `mismatch_id` cleared, `pass`=1.
- `start` pulsed while busy is ignored. `reset_n` asserted mid-RD_TS → outputs 0 immediately, auto-restart after release.
